// File: rtl/mem_responder.sv
// mem_responder: word-addressed RAM behind the CPU's MEM_read/MEM_write
// handshake. It models a fixed number of wait states and answers each
// request with a one-cycle ready pulse and an error qualifier.
module mem_responder #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 8,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              mem_err,
    output logic              busy
);

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    // Request fields captured at acceptance; only these are used afterwards.
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              write_q, write_d;
    logic              err_q, err_d;

    logic [DATA_W-1:0] ram [MEM_DEPTH];

    // Bad request: conflicting read+write, or address beyond the implemented words.
    logic req_err;
    assign req_err = (mem_read & mem_write) | (32'(mem_addr) >= 32'(MEM_DEPTH));

    // Next-state, capture and read-data selection.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        write_d = write_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (mem_read | mem_write) begin
                    addr_d  = mem_addr;
                    wdata_d = mem_wdata;
                    write_d = mem_write;
                    err_d   = req_err;
                    cnt_d   = 4'(WAIT_CYCLES);
                    if (WAIT_CYCLES == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Read data is registered on the edge that enters RESP so it is valid
        // for the whole ready cycle; it then holds until the next response.
        if ((state_d == RESP) && (state_q != RESP)) begin
            if (err_d) begin
                rdata_d = '0;
            end else if (!write_d) begin
                rdata_d = ram[addr_d[IDX_W-1:0]];
            end
        end
    end

    // Control state and response data, cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    // Latched request fields; meaningless until a request is accepted.
    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        write_q <= write_d;
        err_q   <= err_d;
    end

    // RAM write commits on the RESP edge; reset never touches the contents.
    always_ff @(posedge clk) begin
        if ((state_q == RESP) && write_q && !err_q) begin
            ram[addr_q[IDX_W-1:0]] <= wdata_q;
        end
    end

    assign mem_ready = (state_q == RESP);
    assign mem_err   = (state_q == RESP) && err_q;
    assign busy      = (state_q != IDLE);
    assign mem_rdata = rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with two wait states and
// 128 implemented words, one with zero wait states and the full 256 words.
module tb_mem_responder;

    logic        clk;
    logic        rst_n;

    logic        a_read, a_write, a_ready, a_err, a_busy;
    logic [7:0]  a_addr;
    logic [15:0] a_wdata, a_rdata;

    logic        b_read, b_write, b_ready, b_err, b_busy;
    logic [7:0]  b_addr;
    logic [15:0] b_wdata, b_rdata;

    int checks;
    int fails;

    mem_responder #(.DATA_W(16), .ADDR_W(8), .MEM_DEPTH(128), .WAIT_CYCLES(2)) u_a (
        .clk(clk), .rst_n(rst_n), .mem_read(a_read), .mem_write(a_write),
        .mem_addr(a_addr), .mem_wdata(a_wdata), .mem_rdata(a_rdata),
        .mem_ready(a_ready), .mem_err(a_err), .busy(a_busy)
    );

    mem_responder #(.DATA_W(16), .ADDR_W(8), .MEM_DEPTH(256), .WAIT_CYCLES(0)) u_b (
        .clk(clk), .rst_n(rst_n), .mem_read(b_read), .mem_write(b_write),
        .mem_addr(b_addr), .mem_wdata(b_wdata), .mem_rdata(b_rdata),
        .mem_ready(b_ready), .mem_err(b_err), .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One access on instance a. Called 1 time unit after an edge with the DUT idle.
    // lat = edges after the accepting edge until ready is seen (40 = timed out).
    task automatic acc_a(input logic rd, input logic wr, input logic [7:0] addr,
                         input logic [15:0] wd, output int lat,
                         output logic [15:0] rdat, output logic err);
        a_read = rd; a_write = wr; a_addr = addr; a_wdata = wd;
        @(posedge clk); #1;
        lat = 0;
        while (!a_ready && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        rdat = a_rdata; err = a_err;
        a_read = 1'b0; a_write = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic acc_b(input logic rd, input logic wr, input logic [7:0] addr,
                         input logic [15:0] wd, output int lat,
                         output logic [15:0] rdat, output logic err);
        b_read = rd; b_write = wr; b_addr = addr; b_wdata = wd;
        @(posedge clk); #1;
        lat = 0;
        while (!b_ready && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        rdat = b_rdata; err = b_err;
        b_read = 1'b0; b_write = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_read = 0; a_write = 0; a_addr = 0; a_wdata = 0;
        b_read = 0; b_write = 0; b_addr = 0; b_wdata = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({a_ready, a_err, a_busy, a_rdata} !== 19'd0) begin
            $display("FAIL reset_a: got rdy=%b err=%b busy=%b rdata=%h, expected all 0",
                     a_ready, a_err, a_busy, a_rdata);
            fails++;
        end
        checks++;
        if ({b_ready, b_err, b_busy, b_rdata} !== 19'd0) begin
            $display("FAIL reset_b: got rdy=%b err=%b busy=%b rdata=%h, expected all 0",
                     b_ready, b_err, b_busy, b_rdata);
            fails++;
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        int lat; logic [15:0] rd; logic err;
        acc_a(1'b0, 1'b1, 8'h10, 16'hBEEF, lat, rd, err);
        checks++;
        if (lat !== 2 || err !== 1'b0) begin
            $display("FAIL wr_latency: got lat=%0d err=%b, expected lat=2 err=0", lat, err);
            fails++;
        end
        checks++;
        if (a_ready !== 1'b0) begin
            $display("FAIL ready_pulse: got ready=%b after response, expected 0", a_ready);
            fails++;
        end
        acc_a(1'b1, 1'b0, 8'h10, 16'h0000, lat, rd, err);
        checks++;
        if (lat !== 2 || err !== 1'b0 || rd !== 16'hBEEF) begin
            $display("FAIL rd_0x10: got lat=%0d err=%b rdata=%h, expected lat=2 err=0 rdata=beef",
                     lat, err, rd);
            fails++;
        end
        checks++;
        if (a_rdata !== 16'hBEEF) begin
            $display("FAIL rdata_hold: got %h, expected beef", a_rdata);
            fails++;
        end
    endtask

    task automatic test_back_to_back();
        int lat; logic [15:0] rd; logic err;
        acc_b(1'b0, 1'b1, 8'h00, 16'h1111, lat, rd, err);
        acc_b(1'b0, 1'b1, 8'h01, 16'h2222, lat, rd, err);
        checks++;
        if (lat !== 0 || err !== 1'b0) begin
            $display("FAIL b_wr_latency: got lat=%0d err=%b, expected 0 and 0", lat, err);
            fails++;
        end
        b_read = 1'b1; b_addr = 8'h00;
        @(posedge clk); #1;
        checks++;
        if (b_ready !== 1'b1 || b_rdata !== 16'h1111) begin
            $display("FAIL b2b_first: got ready=%b rdata=%h, expected 1 and 1111", b_ready, b_rdata);
            fails++;
        end
        b_addr = 8'h01;
        @(posedge clk); #1;
        checks++;
        if (b_ready !== 1'b0) begin
            $display("FAIL b2b_gap: got ready=%b, expected 0", b_ready);
            fails++;
        end
        @(posedge clk); #1;
        checks++;
        if (b_ready !== 1'b1 || b_rdata !== 16'h2222 || b_err !== 1'b0) begin
            $display("FAIL b2b_second: got ready=%b rdata=%h err=%b, expected 1 2222 0",
                     b_ready, b_rdata, b_err);
            fails++;
        end
        b_read = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_depth_err();
        int lat; logic [15:0] rd; logic err;
        acc_a(1'b0, 1'b1, 8'h00, 16'h5A5A, lat, rd, err);
        acc_a(1'b1, 1'b0, 8'h80, 16'h0000, lat, rd, err);
        checks++;
        if (lat !== 2 || err !== 1'b1 || rd !== 16'h0000) begin
            $display("FAIL rd_oob: got lat=%0d err=%b rdata=%h, expected 2 1 0000", lat, err, rd);
            fails++;
        end
        acc_a(1'b0, 1'b1, 8'h80, 16'hFFFF, lat, rd, err);
        checks++;
        if (lat !== 2 || err !== 1'b1) begin
            $display("FAIL wr_oob: got lat=%0d err=%b, expected 2 1", lat, err);
            fails++;
        end
        acc_a(1'b1, 1'b0, 8'h00, 16'h0000, lat, rd, err);
        checks++;
        if (err !== 1'b0 || rd !== 16'h5A5A) begin
            $display("FAIL no_wrap: got err=%b rdata=%h, expected 0 5a5a", err, rd);
            fails++;
        end
        acc_a(1'b0, 1'b1, 8'h7F, 16'h7E7E, lat, rd, err);
        acc_a(1'b1, 1'b0, 8'h7F, 16'h0000, lat, rd, err);
        checks++;
        if (err !== 1'b0 || rd !== 16'h7E7E) begin
            $display("FAIL last_word: got err=%b rdata=%h, expected 0 7e7e", err, rd);
            fails++;
        end
    endtask

    task automatic test_both_high();
        int lat; logic [15:0] rd; logic err;
        acc_a(1'b0, 1'b1, 8'h05, 16'h0055, lat, rd, err);
        acc_a(1'b1, 1'b1, 8'h05, 16'hAAAA, lat, rd, err);
        checks++;
        if (lat !== 2 || err !== 1'b1 || rd !== 16'h0000) begin
            $display("FAIL rw_conflict: got lat=%0d err=%b rdata=%h, expected 2 1 0000", lat, err, rd);
            fails++;
        end
        acc_a(1'b1, 1'b0, 8'h05, 16'h0000, lat, rd, err);
        checks++;
        if (err !== 1'b0 || rd !== 16'h0055) begin
            $display("FAIL rw_ram_kept: got err=%b rdata=%h, expected 0 0055", err, rd);
            fails++;
        end
    endtask

    task automatic test_reset_mid();
        int lat; logic [15:0] rd; logic err; int pulses;
        acc_a(1'b0, 1'b1, 8'h20, 16'h0777, lat, rd, err);
        a_write = 1'b1; a_addr = 8'h20; a_wdata = 16'h1234;
        @(posedge clk); #1;
        checks++;
        if (a_busy !== 1'b1) begin
            $display("FAIL busy_after_accept: got %b, expected 1", a_busy);
            fails++;
        end
        rst_n = 1'b0;
        #2;
        checks++;
        if (a_busy !== 1'b0 || a_rdata !== 16'h0000) begin
            $display("FAIL async_abort: got busy=%b rdata=%h, expected 0 0000", a_busy, a_rdata);
            fails++;
        end
        rst_n = 1'b1;
        a_write = 1'b0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (a_ready) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            $display("FAIL abort_no_ready: got %0d ready pulses, expected 0", pulses);
            fails++;
        end
        acc_a(1'b1, 1'b0, 8'h20, 16'h0000, lat, rd, err);
        checks++;
        if (err !== 1'b0 || rd !== 16'h0777) begin
            $display("FAIL abort_discard: got err=%b rdata=%h, expected 0 0777", err, rd);
            fails++;
        end
    endtask

    task automatic test_latch();
        int lat; logic [15:0] rd; logic err;
        acc_a(1'b0, 1'b1, 8'h31, 16'h0000, lat, rd, err);
        a_write = 1'b1; a_addr = 8'h30; a_wdata = 16'hC3C3;
        @(posedge clk); #1;
        a_addr = 8'h31; a_wdata = 16'hFFFF;
        lat = 0;
        while (!a_ready && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        a_write = 1'b0;
        checks++;
        if (lat !== 2) begin
            $display("FAIL latch_latency: got %0d, expected 2", lat);
            fails++;
        end
        @(posedge clk); #1;
        acc_a(1'b1, 1'b0, 8'h30, 16'h0000, lat, rd, err);
        checks++;
        if (rd !== 16'hC3C3) begin
            $display("FAIL latch_addr0x30: got %h, expected c3c3", rd);
            fails++;
        end
        acc_a(1'b1, 1'b0, 8'h31, 16'h0000, lat, rd, err);
        checks++;
        if (rd !== 16'h0000) begin
            $display("FAIL latch_addr0x31: got %h, expected 0000", rd);
            fails++;
        end
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        test_reset();
        test_write_read();
        test_back_to_back();
        test_depth_err();
        test_both_high();
        test_reset_mid();
        test_latch();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
